mem_stage_sram_ctrl: RTL and testbench
======================================

Name: mem_stage_sram_ctrl

Overview:
Consumer end of the EX->MEM pipeline interface. Takes the registered EX-stage outputs (wb_en, mem_r_en, mem_w_en, dest, alu_result, st_val) and performs 32-bit loads and stores against an external 16-bit, wait-stated SRAM, two half-word accesses per word. It stalls upstream via ready and registers results toward the WB stage. Non-memory instructions pass through in one cycle.

Parameters:
ADDR_W, 18, SRAM half-word address width.
WAIT_CYCLES, 2, cycles per half-word access (>=1).
MEM_BASE, 32'd1024, byte address mapped to SRAM half-word address 0.

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous active-low reset (0 = reset)
wb_en_in  in  1  writeback enable from EX register
mem_r_en_in  in  1  load request
mem_w_en_in  in  1  store request
dest_in  in  4  destination register
alu_result_in  in  32  effective byte address, or ALU result for non-memory ops
st_val_in  in  32  store data
ready  out  1  0 = freeze upstream; EX register inputs must be held stable
sram_addr  out  ADDR_W  SRAM half-word address
sram_wdata  out  16  SRAM write data
sram_rdata  in  16  SRAM read data
sram_we_n  out  1  SRAM write strobe, active low
wb_en_out  out  1  to WB register
mem_r_en_out  out  1  to WB register (selects mem_data_out)
dest_out  out  4  to WB register
alu_result_out  out  32  to WB register
mem_data_out  out  32  loaded word

Behaviour:
- Reset (async, rst=0): state IDLE; wait counter 0; all outputs 0 except sram_we_n=1 and ready=1. Reset mid-access aborts immediately: sram_we_n rises, no WB output is produced, and the partial word is discarded.
- States:
  - IDLE: if mem_r_en_in or mem_w_en_in, go to LOW and set ready=0 (combinational). Otherwise stay with ready=1.
  - LOW: half 0. Stay WAIT_CYCLES cycles, then go to HIGH.
  - HIGH: half 1. Stay WAIT_CYCLES cycles, then go to DONE.
  - DONE: ready=1 for exactly one cycle, then go to IDLE.
- ready=0 for exactly 1+2*WAIT_CYCLES cycles per memory op.
- If both mem_r_en_in and mem_w_en_in are set, the op is a read; the write is ignored.
- Address calculation: word = (alu_result_in - MEM_BASE) >> 2, truncated. sram_addr = {word[ADDR_W-2:0], half}, with half=0 in LOW and half=1 in HIGH. sram_addr=0 outside LOW/HIGH. Byte offset bits [1:0] are ignored.
- Store: sram_we_n=0 throughout LOW/HIGH. sram_wdata is st_val_in[15:0] in LOW and st_val_in[31:16] in HIGH; 0 otherwise.
- Load: sram_we_n=1. sram_rdata is sampled on the last cycle of LOW into the assembly [15:0], and on the last cycle of HIGH into [31:16].
- WB registers, updated every posedge:
  - ready=1 and state IDLE: load the inputs; mem_data_out=0.
  - ready=1 and state DONE: load the inputs plus the assembled word into mem_data_out.
  - ready=0: load a bubble (wb_en_out=0, mem_r_en_out=0, dest_out=0, alu_result_out=0, mem_data_out=0).
- Back-to-back memory ops: after DONE, the next op needs a fresh IDLE cycle.
- A non-memory op in the IDLE cycle passes through with 1-cycle latency.

Decomposition:
- Package mem_stage_pkg holds:
  - state enum (IDLE, LOW, HIGH, DONE)
  - SRAM_DATA_W=16
  - WORD_W=32
  - address-mapping helper function
- Natural sub-module: mem_wait_counter. Loadable down-counter asserting a last-cycle pulse; reused for the LOW and HIGH phases.

Test Plan:
1. Store 0xDEADBEEF to address 1024 (WAIT_CYCLES=2) -> ready low 5 cycles; SRAM addr 0 written 0xBEEF, addr 1 written 0xDEAD; we_n low 4 cycles; wb_en_out=0 after DONE.
2. Load from 1024 after scenario 1 -> mem_data_out=0xDEADBEEF, mem_r_en_out=1, dest_out=dest_in, one cycle after DONE.
3. Address 1032 -> SRAM addrs 4 then 5; address 1035 -> same addrs (low bits ignored).
4. Non-memory op (wb_en=1, dest=7, alu_result=0x12345678) -> ready stays 1; outputs match on the next edge; mem_data_out=0.
5. Assert rst=0 during HIGH of a store -> sram_we_n=1 and ready=1 immediately; all WB outputs 0; state IDLE after release.
6. Load with both r/w enables set, then an immediate second load -> both treated as reads; second load starts after one IDLE cycle; two separate WB results with no duplicates.

Source files
------------

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types and helpers for the MEM-stage SRAM controller.
package mem_stage_pkg;
   localparam int SRAM_DATA_W = 16;
   localparam int WORD_W      = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef struct packed {
      logic              wb_en;
      logic              mem_r_en;
      logic [3:0]        dest;
      logic [WORD_W-1:0] alu_result;
      logic [WORD_W-1:0] mem_data;
   } wb_rsp_t;

   // Byte address -> SRAM word index; wraps below the base, caller truncates.
   function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] byte_addr,
                                                    input logic [WORD_W-1:0] base);
      return (byte_addr - base) >> 2;
   endfunction
endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// 16-bit wait-stated SRAM bus between the controller (master) and the memory (slave).
interface mem_stage_sram_ctrl_if
   import mem_stage_pkg::*;
#(parameter int ADDR_W = 18);
   logic [ADDR_W-1:0]      sram_addr;
   logic [SRAM_DATA_W-1:0] sram_wdata;
   logic [SRAM_DATA_W-1:0] sram_rdata;
   logic                   sram_we_n;

   modport master (output sram_addr, sram_wdata, sram_we_n, input sram_rdata);
   modport slave  (input sram_addr, sram_wdata, sram_we_n, output sram_rdata);
endinterface

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
// Loadable down-counter timing one half-word access; last is high on its final cycle.
module mem_wait_counter #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic last
);
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   cnt <= '0;
      else if (load)              cnt <= CW'(WAIT_CYCLES - 1);
      else if (en && cnt != '0)   cnt <= cnt - 1'b1;
   end

   assign last = (cnt == '0);
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage: 32-bit loads/stores as two 16-bit SRAM accesses, stalling EX via ready.
module mem_stage_sram_ctrl
   import mem_stage_pkg::*;
#(
   parameter int          ADDR_W      = 18,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] MEM_BASE    = 32'd1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wb_en_in,
   input  logic                       mem_r_en_in,
   input  logic                       mem_w_en_in,
   input  logic [3:0]                 dest_in,
   input  logic [WORD_W-1:0]          alu_result_in,
   input  logic [WORD_W-1:0]          st_val_in,
   output logic                       ready,
   mem_stage_sram_ctrl_if.master      sram,
   output logic                       wb_en_out,
   output logic                       mem_r_en_out,
   output logic [3:0]                 dest_out,
   output logic [WORD_W-1:0]          alu_result_out,
   output logic [WORD_W-1:0]          mem_data_out
);
   state_e              state, nxt;
   logic                last, mem_op, is_wr, access, half, cnt_load;
   logic [ADDR_W-2:0]   word_lo;
   logic [WORD_W-1:0]   asm_word;
   wb_rsp_t             wb;

   assign mem_op  = mem_r_en_in | mem_w_en_in;
   assign is_wr   = mem_w_en_in & ~mem_r_en_in;   // read wins when both are set
   assign access  = (state == LOW) || (state == HIGH);
   assign half    = (state == HIGH);
   assign word_lo = (ADDR_W-1)'(word_index(alu_result_in, MEM_BASE));

   // ready is forced high while in reset so EX is never left frozen.
   assign ready = !rst || (state == DONE) || (state == IDLE && !mem_op);

   assign cnt_load = (state == IDLE && mem_op) || (state == LOW && last);

   mem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
      .clk  (clk),
      .rst  (rst),
      .load (cnt_load),
      .en   (access),
      .last (last)
   );

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (mem_op) nxt = LOW;
         LOW:     if (last)   nxt = HIGH;
         HIGH:    if (last)   nxt = DONE;
         default:             nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   assign sram.sram_addr  = access ? {word_lo, half} : '0;
   assign sram.sram_we_n  = !(access && is_wr);
   assign sram.sram_wdata = (access && is_wr) ? (half ? st_val_in[31:16] : st_val_in[15:0]) : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                           asm_word <= '0;
      else if (state == IDLE && mem_op)   asm_word <= '0;
      else if (mem_r_en_in && last) begin
         if (state == LOW)  asm_word[15:0]  <= sram.sram_rdata;
         if (state == HIGH) asm_word[31:16] <= sram.sram_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        wb <= '0;
      else if (!ready) wb <= '0;
      else             wb <= '{wb_en_in, mem_r_en_in, dest_in, alu_result_in,
                               (state == DONE) ? asm_word : '0};
   end

   assign wb_en_out      = wb.wb_en;
   assign mem_r_en_out   = wb.mem_r_en;
   assign dest_out       = wb.dest;
   assign alu_result_out = wb.alu_result;
   assign mem_data_out   = wb.mem_data;
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Table-driven bench with WB scoreboard and a behavioural 16-bit SRAM.
module tb_mem_stage_sram_ctrl;
   logic        clk, rst;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in;
   logic [3:0]  dest_in;
   logic [31:0] alu_result_in, st_val_in;
   logic        ready, wb_en_out, mem_r_en_out;
   logic [3:0]  dest_out;
   logic [31:0] alu_result_out, mem_data_out;

   mem_stage_sram_ctrl_if #(.ADDR_W(18)) sif ();

   mem_stage_sram_ctrl #(.ADDR_W(18), .WAIT_CYCLES(2), .MEM_BASE(32'd1024)) dut (
      .clk(clk), .rst(rst),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .dest_in(dest_in), .alu_result_in(alu_result_in), .st_val_in(st_val_in),
      .ready(ready), .sram(sif),
      .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .dest_out(dest_out),
      .alu_result_out(alu_result_out), .mem_data_out(mem_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] sram_mem [0:255];
   initial for (int i = 0; i < 256; i++) sram_mem[i] = 16'h0;
   assign sif.sram_rdata = sram_mem[sif.sram_addr[7:0]];
   always @(posedge clk) if (rst && !sif.sram_we_n) sram_mem[sif.sram_addr[7:0]] <= sif.sram_wdata;

   int total = 0, bad = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        wb_en, mem_r_en;
      logic [3:0]  dest;
      logic [31:0] alu, data;
   } exp_t;
   exp_t exp_q[$];

   int we_cnt, first_wa, last_wa;
   always @(negedge clk) begin
      if (rst && !sif.sram_we_n) begin
         if (we_cnt == 0) first_wa = int'(sif.sram_addr);
         last_wa = int'(sif.sram_addr);
         we_cnt++;
      end
   end

   always @(negedge clk) begin
      if (rst && (wb_en_out || mem_r_en_out)) begin
         if (exp_q.size() == 0) chk("wb_unexpected", {31'd0, wb_en_out}, 32'd0);
         else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wb_en_out", {31'd0, wb_en_out}, {31'd0, e.wb_en});
            chk("mem_r_en_out", {31'd0, mem_r_en_out}, {31'd0, e.mem_r_en});
            chk("dest_out", {28'd0, dest_out}, {28'd0, e.dest});
            chk("alu_result_out", alu_result_out, e.alu);
            chk("mem_data_out", mem_data_out, e.data);
         end
      end
   end

   typedef struct {
      logic        wb_en, r, w;
      logic [3:0]  dest;
      logic [31:0] alu, st, data;
      int          low, we, a0, a1;
   } vec_t;

   function automatic vec_t mk(logic wb_en, logic r, logic w, logic [3:0] dest,
                               logic [31:0] alu, logic [31:0] st, logic [31:0] data,
                               int low, int we, int a0, int a1);
      vec_t v;
      v.wb_en = wb_en; v.r = r; v.w = w; v.dest = dest; v.alu = alu; v.st = st;
      v.data = data; v.low = low; v.we = we; v.a0 = a0; v.a1 = a1;
      return v;
   endfunction

   task automatic idle_inputs();
      wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
      dest_in = 0; alu_result_in = 0; st_val_in = 0;
   endtask

   // Called at posedge+1; returns at posedge+1 after the op has been accepted.
   task automatic do_op(input vec_t v);
      int lowcnt, n;
      logic [15:0] lo_half, hi_half;
      wb_en_in = v.wb_en; mem_r_en_in = v.r; mem_w_en_in = v.w;
      dest_in = v.dest; alu_result_in = v.alu; st_val_in = v.st;
      if (v.wb_en || v.r) exp_q.push_back('{v.wb_en, v.r, v.dest, v.alu, v.r ? v.data : 32'd0});
      we_cnt = 0; lowcnt = 0; n = 0;
      @(negedge clk);
      while (!ready && n < 40) begin
         lowcnt++; n++;
         @(negedge clk);
      end
      if (n >= 40) chk("ready_timeout", 32'd0, 32'd1);
      chk("ready_low_cycles", 32'(lowcnt), 32'(v.low));
      chk("we_low_cycles", 32'(we_cnt), 32'(v.we));
      if (v.w && !v.r) begin
         lo_half = v.st[15:0];
         hi_half = v.st[31:16];
         chk("wr_addr_first", 32'(first_wa), 32'(v.a0));
         chk("wr_addr_last", 32'(last_wa), 32'(v.a1));
         chk("sram_lo", {16'd0, sram_mem[v.a0]}, {16'd0, lo_half});
         chk("sram_hi", {16'd0, sram_mem[v.a1]}, {16'd0, hi_half});
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = mk(0, 0, 1, 4'd0,  32'd1024, 32'hDEADBEEF, 32'h0,        5, 4, 0, 1);
      vecs[1] = mk(1, 1, 0, 4'd3,  32'd1024, 32'h0,        32'hDEADBEEF, 5, 0, 0, 0);
      vecs[2] = mk(1, 0, 0, 4'd7,  32'h12345678, 32'h0,    32'h0,        0, 0, 0, 0);
      vecs[3] = mk(0, 0, 1, 4'd0,  32'd1032, 32'hCAFEF00D, 32'h0,        5, 4, 4, 5);
      vecs[4] = mk(0, 0, 1, 4'd0,  32'd1035, 32'h5A5AA5A5, 32'h0,        5, 4, 4, 5);
      vecs[5] = mk(1, 1, 1, 4'd9,  32'd1033, 32'hFFFFFFFF, 32'h5A5AA5A5, 5, 0, 0, 0);
      vecs[6] = mk(1, 1, 0, 4'd10, 32'd1032, 32'h0,        32'h5A5AA5A5, 5, 0, 0, 0);
      vecs[7] = mk(1, 1, 0, 4'd12, 32'd1024, 32'h0,        32'hDEADBEEF, 5, 0, 0, 0);

      rst = 0; idle_inputs(); we_cnt = 0; first_wa = 0; last_wa = 0;
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_we_n", {31'd0, sif.sram_we_n}, 32'd1);
      chk("rst_addr", 32'(sif.sram_addr), 32'd0);
      chk("rst_wb", {wb_en_out, mem_r_en_out, 26'd0, dest_out}, 32'd0);
      chk("rst_alu_data", alu_result_out | mem_data_out, 32'd0);
      rst = 1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) do_op(vecs[i]);

      // Non-memory op: ready stays high, result one edge later.
      wb_en_in = 1; dest_in = 4'd7; alu_result_in = 32'h12345678;
      exp_q.push_back('{1'b1, 1'b0, 4'd7, 32'h12345678, 32'd0});
      @(negedge clk);
      chk("pass_ready", {31'd0, ready}, 32'd1);
      @(posedge clk); #1;
      chk("pass_wb_en", {31'd0, wb_en_out}, 32'd1);
      chk("pass_dest", {28'd0, dest_out}, 32'd7);
      chk("pass_alu", alu_result_out, 32'h12345678);
      chk("pass_data", mem_data_out, 32'd0);
      idle_inputs();

      // Reset asserted during the HIGH half of a store.
      mem_w_en_in = 1; alu_result_in = 32'd1040; st_val_in = 32'h11112222;
      repeat (4) @(negedge clk);
      chk("high_addr", 32'(sif.sram_addr), 32'd9);
      chk("high_we_n", {31'd0, sif.sram_we_n}, 32'd0);
      chk("high_wdata", {16'd0, sif.sram_wdata}, 32'h1111);
      rst = 0; #1;
      chk("abort_we_n", {31'd0, sif.sram_we_n}, 32'd1);
      chk("abort_ready", {31'd0, ready}, 32'd1);
      chk("abort_addr", 32'(sif.sram_addr), 32'd0);
      chk("abort_wb", {wb_en_out, mem_r_en_out, 26'd0, dest_out}, 32'd0);
      chk("abort_alu_data", alu_result_out | mem_data_out, 32'd0);
      idle_inputs();
      @(negedge clk); rst = 1;
      @(posedge clk); #1;
      do_op(mk(1, 0, 0, 4'd5, 32'h000000A5, 32'h0, 32'h0, 0, 0, 0, 0));

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
